// File: rtl/rmt_ingress_pkt_filter.sv
// AXI-Stream ingress filter: classifies each packet on beat 0 (CTRL/DATA/MALFORMED) and forwards or
// discards it whole per mode. Latency 1 cycle; 2-entry skid buffer, registered s_axis_tready.
module rmt_ingress_pkt_filter #(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
   parameter bit          DROP_MALFORMED       = 1'b1,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [1:0]                        mode,
   input  logic                              cnt_clr,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [CNT_WIDTH-1:0]              pass_cnt,
   output logic [CNT_WIDTH-1:0]              drop_cnt
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PASS = 2'd1, ST_DROP = 2'd2} state_t;

   state_t               state_q, state_d;
   logic                 is_ctrl, is_malformed, eff_ctrl, pkt_drop;
   logic                 beat_drop, s_hs, push, pop, pass_inc, drop_inc;
   logic                 rdy_q, rdy_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]        dat_q [2];
   logic [DW-1:0]        dat_d [2];
   logic [KW-1:0]        keep_q [2];
   logic [KW-1:0]        keep_d [2];
   logic [UW-1:0]        user_q [2];
   logic [UW-1:0]        user_d [2];
   logic [1:0]           last_q, last_d;
   logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d, drop_cnt_q, drop_cnt_d;

   assign s_axis_tready = rdy_q;
   assign s_hs          = s_axis_tvalid & rdy_q;

   always_comb begin
      is_ctrl      = ({s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]} == 16'h8100) &&
                     ({s_axis_tdata[8*16 +: 8], s_axis_tdata[8*17 +: 8]} == 16'h0800) &&
                     (s_axis_tdata[8*27 +: 8] == 8'h11) &&
                     ({s_axis_tdata[8*40 +: 8], s_axis_tdata[8*41 +: 8]} == CTRL_UDP_PORT);
      is_malformed = s_axis_tlast & ~s_axis_tkeep[41];
      // A malformed packet that is not dropped outright is handled as DATA.
      eff_ctrl     = is_ctrl & ~is_malformed;
      pkt_drop     = (is_malformed & DROP_MALFORMED) ||
                     (mode == 2'd3) ||
                     (mode == 2'd1 && !eff_ctrl) ||
                     (mode == 2'd2 && eff_ctrl);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (s_hs && !s_axis_tlast) state_d = pkt_drop ? ST_DROP : ST_PASS;
         ST_PASS,
         ST_DROP: if (s_hs && s_axis_tlast) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      beat_drop = (state_q == ST_IDLE) ? pkt_drop : (state_q == ST_DROP);
      push      = s_hs & ~beat_drop;
      pop       = (cnt_q != 2'd0) & m_axis_tready;
      pass_inc  = s_hs & s_axis_tlast & ~beat_drop;
      drop_inc  = s_hs & s_axis_tlast & beat_drop;
   end

   always_comb begin
      dat_d    = dat_q;
      keep_d   = keep_q;
      user_d   = user_q;
      last_d   = last_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         dat_d[wr_ptr_q]  = s_axis_tdata;
         keep_d[wr_ptr_q] = s_axis_tkeep;
         user_d[wr_ptr_q] = s_axis_tuser;
         last_d[wr_ptr_q] = s_axis_tlast;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      // Dropped beats never push, so in DROP the buffer only drains and ready stays high.
      rdy_d = (cnt_d != 2'd2);

      pass_cnt_d = pass_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (pass_inc && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
      if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      if (cnt_clr) begin
         pass_cnt_d = '0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         dat_q      <= '{default: '0};
         keep_q     <= '{default: '0};
         user_q     <= '{default: '0};
         last_q     <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= '0;
         rdy_q      <= 1'b1;
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         dat_q      <= dat_d;
         keep_q     <= keep_d;
         user_q     <= user_d;
         last_q     <= last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         rdy_q      <= rdy_d;
         pass_cnt_q <= pass_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign m_axis_tdata  = dat_q[rd_ptr_q];
   assign m_axis_tkeep  = keep_q[rd_ptr_q];
   assign m_axis_tuser  = user_q[rd_ptr_q];
   assign m_axis_tlast  = last_q[rd_ptr_q];
   assign pass_cnt      = pass_cnt_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rmt_ingress_pkt_filter.sv
// Scoreboard bench for rmt_ingress_pkt_filter: kept beats are queued on s handshake, compared on m handshake.
module tb_rmt_ingress_pkt_filter;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int UW = 128;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          cnt_clr = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic [UW-1:0] s_tuser = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic [CW-1:0] pass_cnt, drop_cnt;

   int    checks = 0;
   int    errors = 0;
   int    vld_seen = 0;
   int    pops = 0;
   bit    tog_en = 1'b0;
   beat_t sb[$];

   rmt_ingress_pkt_filter #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .CTRL_UDP_PORT       (16'hf1f2),
      .DROP_MALFORMED      (1'b1),
      .CNT_WIDTH           (CW)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .mode         (mode),
      .cnt_clr      (cnt_clr),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tuser (s_tuser),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tuser (m_tuser),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .pass_cnt     (pass_cnt),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rnd512();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // kind 0: CTRL; 1: VLAN/IPv4/UDP with another port; 2: TCP carrying the CTRL port value
   function automatic logic [DW-1:0] make_hdr(input int kind);
      logic [DW-1:0] d;
      d = rnd512();
      d[8*12 +: 8] = 8'h81;
      d[8*13 +: 8] = 8'h00;
      d[8*16 +: 8] = 8'h08;
      d[8*17 +: 8] = 8'h00;
      d[8*27 +: 8] = (kind == 2) ? 8'h06 : 8'h11;
      d[8*40 +: 8] = (kind == 1) ? 8'h12 : 8'hf1;
      d[8*41 +: 8] = (kind == 1) ? 8'h34 : 8'hf2;
      return d;
   endfunction

   task automatic monitor();
      beat_t hold, e;
      bit    stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            stall = 1'b0;
         end else begin
            checks++;
            if (s_tready !== (sb.size() < 2)) begin
               errors++;
               $display("FAIL occupancy_ready: s_axis_tready=%0b buffered=%0d", s_tready, sb.size());
            end
            checks++;
            if (m_tvalid !== (sb.size() != 0)) begin
               errors++;
               $display("FAIL out_valid: m_axis_tvalid=%0b expected beats=%0d", m_tvalid, sb.size());
            end
            if (m_tvalid) vld_seen++;
            if (stall) begin
               checks++;
               if (m_tvalid !== 1'b1 || m_tdata !== hold.d || m_tkeep !== hold.k ||
                   m_tuser !== hold.u || m_tlast !== hold.l) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%0b last=%0b keep=%h, required last=%0b keep=%h",
                           m_tvalid, m_tlast, m_tkeep, hold.l, hold.k);
               end
            end
            if (m_tvalid && m_tready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got keep=%h last=%0b with empty scoreboard", m_tkeep, m_tlast);
               end else begin
                  e = sb.pop_front();
                  pops++;
                  if (m_tdata !== e.d || m_tkeep !== e.k || m_tuser !== e.u || m_tlast !== e.l) begin
                     errors++;
                     $display("FAIL beat_data: got keep=%h user=%h last=%0b data[127:0]=%h, required keep=%h user=%h last=%0b data[127:0]=%h",
                              m_tkeep, m_tuser, m_tlast, m_tdata[127:0], e.k, e.u, e.l, e.d[127:0]);
                  end
               end
            end
            stall     = m_tvalid && !m_tready;
            hold.d    = m_tdata;
            hold.k    = m_tkeep;
            hold.u    = m_tuser;
            hold.l    = m_tlast;
         end
      end
   endtask

   task automatic toggler();
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) m_tready = ~m_tready;
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                            input logic l, input bit exp_pass, input logic clr);
      bit    ok = 1'b0;
      beat_t e;
      s_tdata  = d;
      s_tkeep  = k;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      cnt_clr  = clr;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (s_tready) ok = 1'b1;
      end
      @(posedge clk);
      if (ok && exp_pass) begin
         e.d = d; e.k = k; e.u = u; e.l = l;
         sb.push_back(e);
      end
      #1;
      s_tvalid = 1'b0;
      cnt_clr  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL handshake_timeout: s_axis_tready=%0b, required 1 within 200 cycles", s_tready);
      end
   endtask

   task automatic send_pkt(input int nb, input int kind, input bit exp_pass, input logic [KW-1:0] last_keep);
      for (int b = 0; b < nb; b++) begin
         send_beat((b == 0) ? make_hdr(kind) : rnd512(),
                   (b == nb - 1) ? last_keep : {KW{1'b1}},
                   {$urandom, $urandom, $urandom, $urandom}, b == nb - 1, exp_pass, 1'b0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counters();
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      checks++;
      if (pass_cnt !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL cnt_clr: pass=%0d drop=%0d, required 0/0", pass_cnt, drop_cnt);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tuser !== '0 || m_tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b keep=%h last=%0b, required all zero", m_tvalid, m_tkeep, m_tlast);
      end
      checks++;
      if (s_tready !== 1'b1 || pass_cnt !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: ready=%0b pass=%0d drop=%0d, required 1/0/0", s_tready, pass_cnt, drop_cnt);
      end
      @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   task automatic test_drop_all();
      clear_counters();
      mode = 2'd3;
      vld_seen = 0;
      for (int i = 0; i < 11; i++) send_pkt((i % 3) + 1, 0, 1'b0, {KW{1'b1}});
      send_pkt(2, 2, 1'b0, {KW{1'b1}});
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (drop_cnt !== 4'd12 || pass_cnt !== 4'd0 || vld_seen != 0) begin
         errors++;
         $display("FAIL drop_all: drop=%0d pass=%0d valid_cycles=%0d, required 12/0/0", drop_cnt, pass_cnt, vld_seen);
      end
   endtask

   task automatic test_ctrl_latency();
      logic [DW-1:0] d0;
      logic [UW-1:0] u0;
      clear_counters();
      mode = 2'd1;
      m_tready = 1'b1;
      d0 = make_hdr(0);
      u0 = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d0, {KW{1'b1}}, u0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== d0 || m_tuser !== u0 || m_tlast !== 1'b0) begin
         errors++;
         $display("FAIL ctrl_latency: valid=%0b last=%0b one cycle after beat 0, required valid=1 last=0", m_tvalid, m_tlast);
      end
      @(posedge clk);
      #1;
      send_beat(rnd512(), 64'h00000000000fffff, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
      send_pkt(1, 1, 1'b0, {KW{1'b1}});
      drain();
      checks++;
      if (pass_cnt !== 4'd1 || drop_cnt !== 4'd1) begin
         errors++;
         $display("FAIL mode1_counts: pass=%0d drop=%0d, required 1/1", pass_cnt, drop_cnt);
      end
   endtask

   task automatic test_mode2();
      clear_counters();
      mode = 2'd2;
      send_pkt(2, 0, 1'b0, {KW{1'b1}});
      send_pkt(2, 1, 1'b1, 64'h00000000000000ff);
      send_pkt(1, 2, 1'b1, {KW{1'b1}});
      drain();
      checks++;
      if (pass_cnt !== 4'd2 || drop_cnt !== 4'd1) begin
         errors++;
         $display("FAIL mode2_counts: pass=%0d drop=%0d, required 2/1", pass_cnt, drop_cnt);
      end
   endtask

   task automatic test_backpressure();
      int p0;
      clear_counters();
      mode = 2'd0;
      p0 = pops;
      m_tready = 1'b1;
      tog_en = 1'b1;
      send_pkt(3, 1, 1'b1, 64'h0000ffffffffffff);
      send_pkt(3, 0, 1'b1, {KW{1'b1}});
      drain();
      tog_en = 1'b0;
      m_tready = 1'b1;
      checks++;
      if (pops - p0 != 6 || pass_cnt !== 4'd2) begin
         errors++;
         $display("FAIL backpressure: beats_out=%0d pass=%0d, required 6/2", pops - p0, pass_cnt);
      end
   endtask

   task automatic test_malformed();
      clear_counters();
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         send_beat(make_hdr(0), 64'h000000000000001f, '0, 1'b1, 1'b0, 1'b0);
         if (m == 0) begin
            checks++;
            if (drop_cnt !== 4'd1 || pass_cnt !== 4'd0) begin
               errors++;
               $display("FAIL malformed_mode0: drop=%0d pass=%0d, required 1/0", drop_cnt, pass_cnt);
            end
         end
      end
      drain();
      checks++;
      if (drop_cnt !== 4'd4 || pass_cnt !== 4'd0) begin
         errors++;
         $display("FAIL malformed_all_modes: drop=%0d pass=%0d, required 4/0", drop_cnt, pass_cnt);
      end
   endtask

   task automatic test_mode_switch();
      clear_counters();
      mode = 2'd0;
      send_beat(make_hdr(1), {KW{1'b1}}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      mode = 2'd3;
      send_beat(rnd512(), {KW{1'b1}}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
      send_beat(rnd512(), 64'h0fffffffffffffff, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
      send_pkt(2, 1, 1'b0, {KW{1'b1}});
      drain();
      checks++;
      if (pass_cnt !== 4'd1 || drop_cnt !== 4'd1) begin
         errors++;
         $display("FAIL mode_switch: pass=%0d drop=%0d, required 1/1", pass_cnt, drop_cnt);
      end
   endtask

   task automatic test_saturate();
      clear_counters();
      mode = 2'd3;
      for (int i = 0; i < 16; i++) begin
         send_pkt(1, 1, 1'b0, {KW{1'b1}});
         if (i == 14) begin
            checks++;
            if (drop_cnt !== 4'hf) begin
               errors++;
               $display("FAIL count_15: drop=%0d, required 15", drop_cnt);
            end
         end
      end
      checks++;
      if (drop_cnt !== 4'hf) begin
         errors++;
         $display("FAIL saturate: drop=%0d, required 15", drop_cnt);
      end
      send_beat(make_hdr(1), {KW{1'b1}}, '0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (drop_cnt !== 4'h0 || pass_cnt !== 4'h0) begin
         errors++;
         $display("FAIL clr_wins: drop=%0d pass=%0d, required 0/0", drop_cnt, pass_cnt);
      end
   endtask

   task automatic test_reset_mid_packet();
      clear_counters();
      mode = 2'd0;
      m_tready = 1'b0;
      send_beat(make_hdr(1), {KW{1'b1}}, '0, 1'b0, 1'b1, 1'b0);
      aresetn = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: valid=%0b ready=%0b, required 0/1", m_tvalid, s_tready);
      end
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      m_tready = 1'b1;
      mode = 2'd3;
      send_beat(rnd512(), {KW{1'b1}}, '0, 1'b1, 1'b0, 1'b0);
      drain();
      checks++;
      if (drop_cnt !== 4'd1 || pass_cnt !== 4'd0) begin
         errors++;
         $display("FAIL after_reset_beat0: drop=%0d pass=%0d, required 1/0", drop_cnt, pass_cnt);
      end
   endtask

   initial begin
      fork
         monitor();
         toggler();
      join_none
      test_reset();
      test_drop_all();
      test_ctrl_latency();
      test_mode2();
      test_backpressure();
      test_malformed();
      test_mode_switch();
      test_saturate();
      test_reset_mid_packet();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
